box_sprite_writer: RTL and testbench

Runtime writer for the 25x25 box sprite's palette-index memory: accepts a stream of 4-bit palette indices over a valid/ready handshake and stores them in row-major order into a 625-entry RAM. The RAM's read port drives the color mapper exactly as the display path does today: pixel address in, palette index out. The game FSM uses this block to repaint the box, for example after it is pushed onto a target. The display path reads the index every pixel clock; this block is the producer end of that memory.

---
 rtl/box_sprite_writer.sv | 159 +++++++++++++++
 tb/tb_box_sprite_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_sprite_writer.sv
// ============================================================================
//  Module      : box_sprite_writer
//  Description : Runtime writer for the 25x25 box sprite palette-index RAM.
//                Accepts a valid/ready stream of palette indices and stores
//                them row-major into a DEPTH-entry RAM. The registered read
//                port feeds the color mapper (pixel address in, index out).
//                Optional macro BOX_WR_VBLANK_GATE_EN restricts writes to
//                vertical blanking so the displayed sprite never tears.
//                RAM contents are not touched by Reset; power-up contents
//                come from the device configuration image (all zero).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module box_sprite_writer #(
    parameter int DEPTH   = 625,
    parameter int ADDR_W  = 10,
    parameter int IDX_W   = 4,
    parameter int MAX_IDX = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              vblank,
    input  logic [ADDR_W-1:0] read_address,
    output logic [IDX_W-1:0]  read_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------------
    // Constants sized to the datapath so comparisons stay width-exact
    // ------------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_depth     = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [IDX_W-1:0]  c_max_idx   = IDX_W'(MAX_IDX);
    localparam logic [IDX_W-1:0]  c_idx_zero  = '0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_done;
    logic               r_err;
    logic [IDX_W-1:0]   r_read_index;
    logic [IDX_W-1:0]   r_mem [0:DEPTH-1];

    logic               w_gate;
    logic               w_ready;
    logic               w_accept;
    logic               w_last;
    logic               w_bad_idx;
    logic [IDX_W-1:0]   w_wr_data;
    logic               w_rd_in_range;

    // ------------------------------------------------------------------------
    // Write gate: either blanking-only or always open while loading
    // ------------------------------------------------------------------------
`ifdef BOX_WR_VBLANK_GATE_EN
    assign w_gate = vblank;
`else
    // vblank stays on the port for drop-in compatibility but has no effect
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_gate          = 1'b1;
`endif

    // in_ready decodes state (and gate) only, never in_valid
    assign w_ready       = (r_state == ST_LOAD) && w_gate;
    // Writes are blocked during Reset so an aborted load leaves no extra beat
    assign w_accept      = w_ready && in_valid && !Reset;
    assign w_last        = (r_wr_addr == c_last_addr);
    // Out-of-palette indices are replaced by white (0) and flagged
    assign w_bad_idx     = (in_data > c_max_idx);
    assign w_wr_data     = w_bad_idx ? c_idx_zero : in_data;
    assign w_rd_in_range = (read_address < c_depth);

    // ------------------------------------------------------------------------
    // Load control FSM: sequencing, write address, done pulse and sticky err
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_LOAD;
                        r_wr_addr <= '0;
                        r_err     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // start is deliberately ignored here: no mid-load restart
                    if (w_accept) begin
                        if (w_bad_idx) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state   <= ST_IDLE;
                            r_wr_addr <= '0;
                            r_done    <= 1'b1;
                        end else begin
                            r_wr_addr <= r_wr_addr + c_addr_one;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_wr_addr <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sprite RAM write port (no reset: contents survive Reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_mem[r_wr_addr] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Registered read port; same-address write in the same cycle returns the
    // old contents because the RAM update is non-blocking
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_read_index <= '0;
        end else if (w_rd_in_range) begin
            r_read_index <= r_mem[read_address];
        end else begin
            r_read_index <= '0;
        end
    end

    assign in_ready   = w_ready;
    assign busy       = (r_state == ST_LOAD);
    assign done       = r_done;
    assign err        = r_err;
    assign read_index = r_read_index;

endmodule

`default_nettype wire

// File: tb/tb_box_sprite_writer.sv
// ============================================================================
//  Module      : tb_box_sprite_writer
//  Description : Self-checking bench for box_sprite_writer. Directed loads
//                with hand-computed read-back tables plus corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_box_sprite_writer;

    logic       Clk;
    logic       Reset;
    logic       start;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       vblank;
    logic [9:0] read_address;
    logic [3:0] read_index;
    logic       busy;
    logic       done;
    logic       err;

    int errs;
    int checks;

    typedef struct {
        int         phase;
        logic [9:0] addr;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t tab [0:23];

    box_sprite_writer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .vblank       (vblank),
        .read_address (read_address),
        .read_index   (read_index),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // one clock, then settle past the edge before driving or sampling
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one load from IDLE. Beat data is (beat+mode)%3, except bad_beat
    // which carries 7. toggle inserts an idle cycle after every beat.
    // stop_after>=0 abandons the load once that many beats were sent.
    task automatic run_load(input int mode, input bit toggle, input int bad_beat,
                            input int stop_after, input int mid_start,
                            output int edges, output bit done_seen);
        int  beat;
        bit  phase;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        edges     = 0;
        beat      = 0;
        phase     = 1'b0;
        done_seen = 1'b0;
        while (edges < 3000 && !done_seen) begin
            if (beat == stop_after) break;
            if ((!toggle || !phase) && beat < 625) begin
                in_valid = 1'b1;
                in_data  = (beat == bad_beat) ? 4'd7 : 4'((beat + mode) % 3);
            end else begin
                in_valid = 1'b0;
            end
            phase = ~phase;
            start = (edges == mid_start);
            step();
            edges++;
            if (in_valid) beat++;
            start     = 1'b0;
            done_seen = done;
        end
        in_valid = 1'b0;
    endtask

    task automatic read_phase(input int ph);
        for (int i = 0; i < 24; i++) begin
            if (tab[i].phase == ph) begin
                read_address = tab[i].addr;
                step();
                chk($sformatf("rd_p%0d_a%0d", ph, tab[i].addr),
                    int'(read_index), int'(tab[i].exp));
            end
        end
    endtask

    initial begin
        int edges;
        bit done_seen;
        bit any_done;
        int acc;

        errs   = 0;
        checks = 0;
        // phase 1: after a clean load with (addr%3)
        tab[0]  = '{1, 10'd0,    4'd0};
        tab[1]  = '{1, 10'd1,    4'd1};
        tab[2]  = '{1, 10'd2,    4'd2};
        tab[3]  = '{1, 10'd624,  4'd0};
        tab[4]  = '{1, 10'd300,  4'd0};
        tab[5]  = '{1, 10'd311,  4'd2};
        tab[6]  = '{1, 10'd700,  4'd0};
        tab[7]  = '{1, 10'd1023, 4'd0};
        // phase 2: load of ((addr+1)%3) with beat 10 = 7 (stored as 0)
        tab[8]  = '{2, 10'd0,    4'd1};
        tab[9]  = '{2, 10'd1,    4'd2};
        tab[10] = '{2, 10'd9,    4'd1};
        tab[11] = '{2, 10'd10,   4'd0};
        tab[12] = '{2, 10'd12,   4'd1};
        tab[13] = '{2, 10'd624,  4'd1};
        tab[14] = '{2, 10'd625,  4'd0};
        tab[15] = '{2, 10'd2,    4'd0};
        // phase 3: 300 beats of ((addr+2)%3) then Reset; 300+ keeps phase 2
        tab[16] = '{3, 10'd0,    4'd2};
        tab[17] = '{3, 10'd2,    4'd1};
        tab[18] = '{3, 10'd298,  4'd0};
        tab[19] = '{3, 10'd299,  4'd1};
        tab[20] = '{3, 10'd300,  4'd1};
        tab[21] = '{3, 10'd301,  4'd2};
        tab[22] = '{3, 10'd624,  4'd1};
        tab[23] = '{3, 10'd1,    4'd0};

        Reset        = 1'b1;
        start        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        read_address = '0;
`ifdef BOX_WR_VBLANK_GATE_EN
        vblank = 1'b1;
`else
        vblank = 1'b0;
`endif
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_read_index", read_index, 0);
        Reset = 1'b0;
        step();

        // full continuous load
        run_load(0, 1'b0, -1, -1, -1, edges, done_seen);
        chk("l1_done_seen", done_seen, 1);
        chk("l1_done_latency", edges, 625);
        chk("l1_busy_at_done", busy, 0);
        chk("l1_err", err, 0);
        step();
        chk("l1_done_width", done, 0);
        read_phase(1);

        // toggling valid, bad index at beat 10, ignored start mid-load
        run_load(1, 1'b1, 10, -1, 400, edges, done_seen);
        chk("l2_done_seen", done_seen, 1);
        chk("l2_done_latency", edges, 1249);
        chk("l2_busy_at_done", busy, 0);
        chk("l2_err", err, 1);
        step();
        chk("l2_done_width", done, 0);
        chk("l2_err_sticky", err, 1);
        read_phase(2);

        // start clears err; abandon after 300 beats with Reset
        run_load(2, 1'b0, -1, 300, -1, edges, done_seen);
        chk("l3_err_cleared", err, 0);
        chk("l3_no_done", done_seen, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("l3_rst_busy", busy, 0);
        chk("l3_rst_ready", in_ready, 0);
        any_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            any_done = any_done | done;
        end
        chk("l3_done_never", any_done, 0);
        read_phase(3);

        // restart rewrites from 0; read-before-write on address 2
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd1;
        step();
        in_data = 4'd0;
        step();
        in_data      = 4'd2;
        read_address = 10'd2;
        step();
        chk("rbw_old_value", read_index, 1);
        in_valid = 1'b0;
        step();
        chk("rbw_new_value", read_index, 2);
        chk("stall_busy", busy, 1);
        read_address = 10'd0;
        step();
        chk("rewrite_addr0", read_index, 1);
        read_address = 10'd700;
        step();
        chk("rd_out_of_range", read_index, 0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();

`ifdef BOX_WR_VBLANK_GATE_EN
        // gated writes: nothing while vblank low, one beat per vblank cycle
        vblank = 1'b0;
        start  = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd1;
        acc      = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) acc++;
            step();
        end
        chk("gate_closed_accepts", acc, 0);
        vblank = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready && in_valid) acc++;
            step();
        end
        vblank = 1'b0;
        #1;
        chk("gate_open_accepts", acc, 100);
        chk("gate_ready_low", in_ready, 0);
        in_valid = 1'b0;
        Reset    = 1'b1;
        step();
        Reset = 1'b0;
        step();
`else
        acc = 0;
        chk("idle_ready", in_ready + acc, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
